// File: rtl/flags_pkg.sv
// -----------------------------------------------------------------------------
// flags_pkg
// Shared definitions for the CPU flag-register sequencer.
//   WIDTH / DEPTH : default flag vector width and shadow-stack depth
//   FLAG_*        : bit position of each flag inside the flag vector
//   state_t       : sequencer states (IDLE, HOLD)
// -----------------------------------------------------------------------------
package flags_pkg;

    localparam int WIDTH = 6;
    localparam int DEPTH = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_P = 4;
    localparam int FLAG_I = 5;

    // HOLD lasts one cycle after a restore so the restored flags are
    // observable before any ALU or software write can overwrite them.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/flags_stack.sv
// -----------------------------------------------------------------------------
// flags_stack
// DEPTH x WIDTH LIFO holding saved flag words for nested interrupts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (occupancy only)
//   push, din  : push din when not full; a push on full is ignored
//   pop        : drop the top entry when not empty; a pop on empty is ignored
//   dout       : current top entry (undefined when empty)
//   depth      : occupancy, 0..DEPTH
//   full/empty : depth==DEPTH / depth==0
// The caller never pushes and pops in the same cycle.
// -----------------------------------------------------------------------------
module flags_stack #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
    assign wr_idx  = AW'(depth);
    assign top_idx = AW'(depth - DW'(1));
    assign dout    = mem[top_idx];

    // Storage is deliberately left unreset; only occupancy defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    // Occupancy saturates at both ends instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/flags_ctrl.sv
// -----------------------------------------------------------------------------
// flags_ctrl
// Arbitrates ALU updates, software writes and interrupt save/restore into a
// single flag-register write per cycle, with a LIFO shadow stack of saved flags.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   alu_req/alu_mask/alu_flags  : masked ALU update request, alu_gnt accepts
//   sw_req/sw_flags             : whole-word software write, sw_gnt accepts
//   save_req / save_gnt         : push current flags
//   restore_req / restore_gnt   : pop flags from the stack
//   err_clr                     : clears sticky err
//   flags                       : current flag value (registered)
//   flag_we / flag_wdata        : one-cycle write pulse and data (registered)
//   depth / full / empty        : stack occupancy
//   err                         : sticky push-on-full / pop-on-empty error
// Priority is restore > save > sw > alu; save may pair with sw or alu.
// -----------------------------------------------------------------------------
module flags_ctrl
    import flags_pkg::*;
#(
    parameter int WIDTH = flags_pkg::WIDTH,
    parameter int DEPTH = flags_pkg::DEPTH,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_req,
    input  logic [WIDTH-1:0] alu_mask,
    input  logic [WIDTH-1:0] alu_flags,
    output logic             alu_gnt,
    input  logic             sw_req,
    input  logic [WIDTH-1:0] sw_flags,
    output logic             sw_gnt,
    input  logic             save_req,
    output logic             save_gnt,
    input  logic             restore_req,
    output logic             restore_gnt,
    input  logic             err_clr,
    output logic [WIDTH-1:0] flags,
    output logic             flag_we,
    output logic [WIDTH-1:0] flag_wdata,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             err
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] stack_dout;
    logic [WIDTH-1:0] alu_result;
    logic             push_err;
    logic             pop_err;

    flags_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (save_gnt),
        .pop   (restore_gnt),
        .din   (flags),
        .dout  (stack_dout),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    assign alu_result = (flags & ~alu_mask) | (alu_flags & alu_mask);
    assign push_err   = save_gnt && full;
    assign pop_err    = restore_gnt && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grants depend only on requests and state. Gating with rst_n keeps every
    // grant low while reset is asserted. sw and alu are locked out in HOLD.
    always_comb begin
        alu_gnt     = 1'b0;
        sw_gnt      = 1'b0;
        save_gnt    = 1'b0;
        restore_gnt = 1'b0;
        next_state  = IDLE;
        if (rst_n) begin
            restore_gnt = restore_req;
            save_gnt    = save_req && !restore_req;
            sw_gnt      = sw_req && !restore_req && (state == IDLE);
            alu_gnt     = alu_req && !restore_req && !sw_req && (state == IDLE);
        end
        if (restore_gnt) begin
            next_state = HOLD;
        end
    end

    // A restore on an empty stack is granted but leaves flags untouched and
    // does not pulse flag_we; save never alters flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= '0;
            flag_we    <= 1'b0;
            flag_wdata <= '0;
        end else begin
            flag_we <= 1'b0;
            if (restore_gnt) begin
                if (!empty) begin
                    flags      <= stack_dout;
                    flag_we    <= 1'b1;
                    flag_wdata <= stack_dout;
                end
            end else if (sw_gnt) begin
                flags      <= sw_flags;
                flag_we    <= 1'b1;
                flag_wdata <= sw_flags;
            end else if (alu_gnt) begin
                flags      <= alu_result;
                flag_we    <= 1'b1;
                flag_wdata <= alu_result;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (push_err || pop_err) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flags_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flags_ctrl
// Table-driven directed bench for flags_ctrl: each row is one clock cycle of
// requests, with the grants expected before the edge and the register state
// expected after it. Reset behaviour is checked in separate sequences.
// -----------------------------------------------------------------------------
module tb_flags_ctrl;

    localparam int W  = 6;
    localparam int D  = 4;
    localparam int DW = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic          alu_req;
    logic [W-1:0]  alu_mask;
    logic [W-1:0]  alu_flags;
    logic          alu_gnt;
    logic          sw_req;
    logic [W-1:0]  sw_flags;
    logic          sw_gnt;
    logic          save_req;
    logic          save_gnt;
    logic          restore_req;
    logic          restore_gnt;
    logic          err_clr;
    logic [W-1:0]  flags;
    logic          flag_we;
    logic [W-1:0]  flag_wdata;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          err;

    int checks;
    int passes;

    typedef struct {
        logic          alu_req;
        logic [W-1:0]  alu_mask;
        logic [W-1:0]  alu_flags;
        logic          sw_req;
        logic [W-1:0]  sw_flags;
        logic          save_req;
        logic          restore_req;
        logic          err_clr;
        logic [3:0]    gnt;       // {restore, save, sw, alu}
        logic [W-1:0]  flags;
        logic          we;
        logic [DW-1:0] depth;
        logic          err;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    flags_ctrl #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_req     (alu_req),
        .alu_mask    (alu_mask),
        .alu_flags   (alu_flags),
        .alu_gnt     (alu_gnt),
        .sw_req      (sw_req),
        .sw_flags    (sw_flags),
        .sw_gnt      (sw_gnt),
        .save_req    (save_req),
        .save_gnt    (save_gnt),
        .restore_req (restore_req),
        .restore_gnt (restore_gnt),
        .err_clr     (err_clr),
        .flags       (flags),
        .flag_we     (flag_we),
        .flag_wdata  (flag_wdata),
        .depth       (depth),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic ar, input logic [W-1:0] am, input logic [W-1:0] af,
        input logic sr, input logic [W-1:0] sf,
        input logic sv, input logic rs, input logic ec,
        input logic [3:0] g, input logic [W-1:0] f, input logic we,
        input logic [DW-1:0] dp, input logic er);
        vec_t v;
        v.alu_req = ar; v.alu_mask = am; v.alu_flags = af;
        v.sw_req = sr; v.sw_flags = sf;
        v.save_req = sv; v.restore_req = rs; v.err_clr = ec;
        v.gnt = g; v.flags = f; v.we = we; v.depth = dp; v.err = er;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        alu_req     = v.alu_req;
        alu_mask    = v.alu_mask;
        alu_flags   = v.alu_flags;
        sw_req      = v.sw_req;
        sw_flags    = v.sw_flags;
        save_req    = v.save_req;
        restore_req = v.restore_req;
        err_clr     = v.err_clr;
    endtask

    task automatic drive_idle();
        alu_req = 1'b0; alu_mask = '0; alu_flags = '0;
        sw_req = 1'b0; sw_flags = '0;
        save_req = 1'b0; restore_req = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " flags"},   32'(flags), 32'h0);
        check_output({tag, " we"},      32'(flag_we), 32'h0);
        check_output({tag, " wdata"},   32'(flag_wdata), 32'h0);
        check_output({tag, " depth"},   32'(depth), 32'h0);
        check_output({tag, " empty"},   32'(empty), 32'h1);
        check_output({tag, " full"},    32'(full), 32'h0);
        check_output({tag, " err"},     32'(err), 32'h0);
        check_output({tag, " gnt"},
                     32'({restore_gnt, save_gnt, sw_gnt, alu_gnt}), 32'h0);
    endtask

    initial begin
        checks = 0;
        passes = 0;

        // Row fields: alu_req, mask, alu_flags, sw_req, sw_flags, save, restore,
        // err_clr | gnt{rs,sv,sw,alu}, flags after, we after, depth after, err after
        vecs[0]  = mk(1, 6'b000011, 6'b111111, 0, 6'b000000, 0, 0, 0, 4'b0001, 6'b000011, 1, 0, 0);
        vecs[1]  = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 4'b0000, 6'b000011, 0, 0, 0);
        vecs[2]  = mk(1, 6'b111111, 6'b000000, 1, 6'b101010, 0, 0, 0, 4'b0010, 6'b101010, 1, 0, 0);
        vecs[3]  = mk(1, 6'b111111, 6'b000000, 0, 6'b000000, 0, 0, 0, 4'b0001, 6'b000000, 1, 0, 0);
        vecs[4]  = mk(1, 6'b000000, 6'b111111, 0, 6'b000000, 0, 0, 0, 4'b0001, 6'b000000, 1, 0, 0);
        vecs[5]  = mk(0, 6'b000000, 6'b000000, 1, 6'b010101, 0, 0, 0, 4'b0010, 6'b010101, 1, 0, 0);
        vecs[6]  = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 1, 0, 0, 4'b0100, 6'b010101, 0, 1, 0);
        vecs[7]  = mk(0, 6'b000000, 6'b000000, 1, 6'b111111, 0, 0, 0, 4'b0010, 6'b111111, 1, 1, 0);
        vecs[8]  = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b010101, 1, 0, 0);
        vecs[9]  = mk(1, 6'b111111, 6'b001100, 0, 6'b000000, 0, 0, 0, 4'b0000, 6'b010101, 0, 0, 0);
        vecs[10] = mk(1, 6'b111111, 6'b001100, 0, 6'b000000, 0, 0, 0, 4'b0001, 6'b001100, 1, 0, 0);
        vecs[11] = mk(0, 6'b000000, 6'b000000, 1, 6'b000001, 0, 0, 0, 4'b0010, 6'b000001, 1, 0, 0);
        vecs[12] = mk(1, 6'b111111, 6'b100000, 0, 6'b000000, 1, 0, 0, 4'b0101, 6'b100000, 1, 1, 0);
        vecs[13] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b000001, 1, 0, 0);
        vecs[14] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 4'b0000, 6'b000001, 0, 0, 0);
        vecs[15] = mk(0, 6'b000000, 6'b000000, 1, 6'b000010, 1, 0, 0, 4'b0110, 6'b000010, 1, 1, 0);
        vecs[16] = mk(0, 6'b000000, 6'b000000, 1, 6'b000100, 1, 0, 0, 4'b0110, 6'b000100, 1, 2, 0);
        vecs[17] = mk(0, 6'b000000, 6'b000000, 1, 6'b001000, 1, 0, 0, 4'b0110, 6'b001000, 1, 3, 0);
        vecs[18] = mk(0, 6'b000000, 6'b000000, 1, 6'b010000, 1, 0, 0, 4'b0110, 6'b010000, 1, 4, 0);
        vecs[19] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 1, 0, 0, 4'b0100, 6'b010000, 0, 4, 1);
        vecs[20] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 1, 1, 0, 4'b1000, 6'b001000, 1, 3, 1);
        vecs[21] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b000100, 1, 2, 1);
        vecs[22] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b000010, 1, 1, 1);
        vecs[23] = mk(1, 6'b111111, 6'b111000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b000001, 1, 0, 1);
        vecs[24] = mk(1, 6'b111111, 6'b111000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b000001, 0, 0, 1);
        vecs[25] = mk(1, 6'b111111, 6'b111000, 0, 6'b000000, 0, 0, 1, 4'b0000, 6'b000001, 0, 0, 0);
        vecs[26] = mk(1, 6'b111111, 6'b111000, 0, 6'b000000, 0, 0, 0, 4'b0001, 6'b111000, 1, 0, 0);
        vecs[27] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 1, 0, 4'b1000, 6'b111000, 0, 0, 1);
        vecs[28] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 1, 1, 4'b1000, 6'b111000, 0, 0, 1);
        vecs[29] = mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 1, 4'b0000, 6'b111000, 0, 0, 0);
        vecs[30] = mk(1, 6'b111111, 6'b000111, 0, 6'b000000, 0, 0, 0, 4'b0001, 6'b000111, 1, 0, 0);

        // Reset with every request asserted: grants must stay low.
        rst_n = 1'b0;
        drive_idle();
        alu_req = 1'b1; sw_req = 1'b1; save_req = 1'b1; restore_req = 1'b1;
        #2;
        check_reset_state("reset");

        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d gnt", i),
                         32'({restore_gnt, save_gnt, sw_gnt, alu_gnt}), 32'(vecs[i].gnt));
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d flags", i), 32'(flags), 32'(vecs[i].flags));
            check_output($sformatf("v%0d we", i), 32'(flag_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check_output($sformatf("v%0d wdata", i), 32'(flag_wdata), 32'(vecs[i].flags));
            end
            check_output($sformatf("v%0d depth", i), 32'(depth), 32'(vecs[i].depth));
            check_output($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].depth == DW'(D)));
            check_output($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].depth == '0));
            check_output($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
        end

        // Build flags=101010, depth=2, err=1, then drop rst_n between edges.
        @(negedge clk);
        drive_idle();
        restore_req = 1'b1;
        @(negedge clk);
        drive_idle();
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b1;
        sw_req   = 1'b1;
        sw_flags = 6'b101010;
        @(posedge clk);
        #1;
        check_output("pre-reset flags", 32'(flags), 32'(6'b101010));
        check_output("pre-reset depth", 32'(depth), 32'd2);
        check_output("pre-reset err", 32'(err), 32'd1);
        check_output("pre-reset we", 32'(flag_we), 32'd1);
        #2;
        alu_req = 1'b1; restore_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_state("async reset");

        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // First transaction after reset behaves from a clean state.
        @(negedge clk);
        alu_req   = 1'b1;
        alu_mask  = 6'b110000;
        alu_flags = 6'b111111;
        #1;
        check_output("post-reset alu gnt", 32'(alu_gnt), 32'd1);
        @(posedge clk);
        #1;
        check_output("post-reset flags", 32'(flags), 32'(6'b110000));
        check_output("post-reset we", 32'(flag_we), 32'd1);
        @(negedge clk);
        drive_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
